// File: rtl/cube_color_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cube_color_ctrl
// Description : Tracks the top colour of the 28 pyramid cubes. Qbert and
//               fantome landing requests are arbitrated round-robin, checked
//               for a one-hot position and applied one at a time. The block
//               keeps a running count of cubes at 1 and pulses win_pulse once
//               when all 28 cubes are set.
//               Optional feature: define CUBE_COLOR_FANTOME_EN to arbitrate
//               the fantome requester. When it is undefined, only Qbert is
//               granted and ft_land_ready stays low.
// Ports       : CLK_33         - single clock, rising edge
//               reset          - asynchronous active-low reset
//               qb_land_*      - Qbert landing valid/ready/one-hot position
//               ft_land_*      - fantome landing valid/ready/one-hot position
//               mode           - 0 = Qbert sets cube, 1 = Qbert toggles cube
//               clear          - synchronous level restart (top priority)
//               color_state    - per-cube top colour
//               cubes_done     - number of cubes at 1 (0..28)
//               win_pulse      - one-cycle pulse after the last cube is set
//               busy           - FSM not idle
//               pos_err        - sticky: an accepted position was not one-hot
// Revision    : 1.0 - initial release
// ============================================================================
module cube_color_ctrl (
  input  logic        CLK_33,
  input  logic        reset,
  input  logic        qb_land_valid,
  input  logic [27:0] qb_land_pos,
  output logic        qb_land_ready,
  input  logic        ft_land_valid,
  input  logic [27:0] ft_land_pos,
  output logic        ft_land_ready,
  input  logic        mode,
  input  logic        clear,
  output logic [27:0] color_state,
  output logic [4:0]  cubes_done,
  output logic        win_pulse,
  output logic        busy,
  output logic        pos_err
);

  localparam logic [4:0] c_ALL_DONE = 5'd28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2,
    WIN   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [27:0] r_pos;
  logic        r_is_qb;
  logic        r_new_bit;
  logic        r_last_qb;      // 1 = last grant went to Qbert
  logic        r_win_seen;
  logic [27:0] r_color_state;
  logic [4:0]  r_cubes_done;
  logic        r_win_pulse;
  logic        r_pos_err;

  logic        w_ft_valid;
  logic [27:0] w_ft_pos;
  logic        w_grant_qb;
  logic        w_grant_ft;
  logic        w_onehot;
  logic        w_old_bit;
  logic [4:0]  w_count_next;

`ifdef CUBE_COLOR_FANTOME_EN
  assign w_ft_valid = ft_land_valid;
  assign w_ft_pos   = ft_land_pos;
`else
  // Fantome inputs are kept on the port list but have no effect.
  logic w_unused_ft;
  assign w_unused_ft = ^{ft_land_valid, ft_land_pos};
  assign w_ft_valid  = 1'b0;
  assign w_ft_pos    = 28'd0;
`endif

  assign w_onehot  = (r_pos != 28'd0) && ((r_pos & (r_pos - 28'd1)) == 28'd0);
  assign w_old_bit = |(r_color_state & r_pos);

  // Incremental count: only a real 0->1 or 1->0 change moves it, which keeps
  // it inside 0..28 without a popcount.
  always_comb begin
    w_count_next = r_cubes_done;
    if (r_new_bit && !w_old_bit) begin
      w_count_next = r_cubes_done + 5'd1;
    end else if (!r_new_bit && w_old_bit) begin
      w_count_next = r_cubes_done - 5'd1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and grants. Grants are held off during reset and during
  // a clear cycle so that no transfer can coincide with a restart.
  always_comb begin
    w_next     = r_state;
    w_grant_qb = 1'b0;
    w_grant_ft = 1'b0;
    if (reset && !clear && (r_state == IDLE)) begin
      if (qb_land_valid && w_ft_valid) begin
        if (r_last_qb) begin
          w_grant_ft = 1'b1;
        end else begin
          w_grant_qb = 1'b1;
        end
      end else if (qb_land_valid) begin
        w_grant_qb = 1'b1;
      end else if (w_ft_valid) begin
        w_grant_ft = 1'b1;
      end
    end
    case (r_state)
      IDLE:    if (w_grant_qb || w_grant_ft) w_next = CHECK;
      CHECK:   w_next = w_onehot ? APPLY : IDLE;
      APPLY:   w_next = (w_count_next == c_ALL_DONE) ? WIN : IDLE;
      WIN:     w_next = WIN;
      default: w_next = IDLE;
    endcase
    if (clear) begin
      w_next = IDLE;
    end
  end

  // Datapath
  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      r_pos         <= 28'd0;
      r_is_qb       <= 1'b0;
      r_new_bit     <= 1'b0;
      r_last_qb     <= 1'b0;
      r_win_seen    <= 1'b0;
      r_color_state <= 28'd0;
      r_cubes_done  <= 5'd0;
      r_win_pulse   <= 1'b0;
      r_pos_err     <= 1'b0;
    end else if (clear) begin
      r_win_seen    <= 1'b0;
      r_color_state <= 28'd0;
      r_cubes_done  <= 5'd0;
      r_win_pulse   <= 1'b0;
      r_pos_err     <= 1'b0;
    end else begin
      // Pulse on the first cycle spent in WIN, once per entry.
      r_win_pulse <= (r_state == WIN) && !r_win_seen;
      r_win_seen  <= (r_state == WIN);
      case (r_state)
        IDLE: begin
          if (w_grant_qb || w_grant_ft) begin
            r_pos     <= w_grant_qb ? qb_land_pos : w_ft_pos;
            r_is_qb   <= w_grant_qb;
            r_last_qb <= w_grant_qb;
          end
        end
        CHECK: begin
          if (w_onehot) begin
            r_new_bit <= r_is_qb ? (mode ? ~w_old_bit : 1'b1) : 1'b0;
          end else begin
            r_pos_err <= 1'b1;
          end
        end
        APPLY: begin
          r_color_state <= r_new_bit ? (r_color_state | r_pos)
                                     : (r_color_state & ~r_pos);
          r_cubes_done  <= w_count_next;
        end
        default: ;
      endcase
    end
  end

  assign qb_land_ready = w_grant_qb;
  assign ft_land_ready = w_grant_ft;
  assign color_state   = r_color_state;
  assign cubes_done    = r_cubes_done;
  assign win_pulse     = r_win_pulse;
  assign pos_err       = r_pos_err;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cube_color_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube_color_ctrl
// Description : Directed self-checking bench for cube_color_ctrl. Fantome
//               checks follow CUBE_COLOR_FANTOME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_color_ctrl;

  logic        clk;
  logic        reset;
  logic        qb_land_valid;
  logic [27:0] qb_land_pos;
  logic        qb_land_ready;
  logic        ft_land_valid;
  logic [27:0] ft_land_pos;
  logic        ft_land_ready;
  logic        mode;
  logic        clear;
  logic [27:0] color_state;
  logic [4:0]  cubes_done;
  logic        win_pulse;
  logic        busy;
  logic        pos_err;

  int n_tests;
  int n_failed;

  cube_color_ctrl u_dut (
    .CLK_33        (clk),
    .reset         (reset),
    .qb_land_valid (qb_land_valid),
    .qb_land_pos   (qb_land_pos),
    .qb_land_ready (qb_land_ready),
    .ft_land_valid (ft_land_valid),
    .ft_land_pos   (ft_land_pos),
    .ft_land_ready (ft_land_ready),
    .mode          (mode),
    .clear         (clear),
    .color_state   (color_state),
    .cubes_done    (cubes_done),
    .win_pulse     (win_pulse),
    .busy          (busy),
    .pos_err       (pos_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_clear;
    logic        mode;
    logic [27:0] pos;
    logic [27:0] exp_color;
    logic [4:0]  exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Full Qbert transaction; returns #1 after the edge where the write lands.
  task automatic qb_land(input logic [27:0] pos, input logic m);
    @(negedge clk);
    mode          = m;
    qb_land_pos   = pos;
    qb_land_valid = 1'b1;
    #1;
    check("qb_ready", {31'd0, qb_land_ready}, 32'd1);
    @(posedge clk);
    #1;
    qb_land_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wins;
    int readies;
    n_tests       = 0;
    n_failed      = 0;
    reset         = 1'b0;
    qb_land_valid = 1'b1;
    qb_land_pos   = 28'h1;
    ft_land_valid = 1'b0;
    ft_land_pos   = 28'h0;
    mode          = 1'b0;
    clear         = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 28'h0000001, 28'h0000001, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 28'h0000001, 28'h0000001, 5'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 28'h0000010, 28'h0000010, 5'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 28'h0000010, 28'h0000000, 5'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 28'h0000004, 28'h0000004, 5'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 28'h0000003, 28'h0000004, 5'd1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 28'h0000000, 28'h0000004, 5'd1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 28'h8000000, 28'h8000004, 5'd2, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 28'h0000020, 28'h0000020, 5'd1, 1'b0};

    // Reset state (valid held high: ready must stay low under reset)
    repeat (2) @(negedge clk);
    check("rst_qb_ready", {31'd0, qb_land_ready}, 32'd0);
    check("rst_color", {4'd0, color_state}, 32'd0);
    check("rst_done", {27'd0, cubes_done}, 32'd0);
    check("rst_win", {31'd0, win_pulse}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, pos_err}, 32'd0);
    qb_land_valid = 1'b0;
    reset = 1'b1;

    // Arbitration right after reset: Qbert wins the first tie
    @(negedge clk);
    qb_land_pos   = 28'h20;
    ft_land_pos   = 28'h20;
    qb_land_valid = 1'b1;
    ft_land_valid = 1'b1;
    #1;
    check("tie_qb_ready", {31'd0, qb_land_ready}, 32'd1);
    check("tie_ft_ready", {31'd0, ft_land_ready}, 32'd0);
    @(posedge clk);
    #1;
    qb_land_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("tie_color", {4'd0, color_state}, 32'h20);
    check("tie_done", {27'd0, cubes_done}, 32'd1);
`ifdef CUBE_COLOR_FANTOME_EN
    check("ft_ready_next", {31'd0, ft_land_ready}, 32'd1);
    @(posedge clk);
    #1;
    ft_land_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("ft_color", {4'd0, color_state}, 32'h0);
    check("ft_done", {27'd0, cubes_done}, 32'd0);
`else
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ft_land_ready) readies++;
    end
    check("ft_ready_never", readies, 32'd0);
    check("ft_no_busy", {31'd0, busy}, 32'd0);
    check("ft_color_kept", {4'd0, color_state}, 32'h20);
    ft_land_valid = 1'b0;
`endif

    // Table of Qbert landings
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_clear) do_clear();
      qb_land(vecs[i].pos, vecs[i].mode);
      check($sformatf("vec%0d_color", i), {4'd0, color_state}, {4'd0, vecs[i].exp_color});
      check($sformatf("vec%0d_done", i), {27'd0, cubes_done}, {27'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_err", i), {31'd0, pos_err}, {31'd0, vecs[i].exp_err});
    end

    // Fill the pyramid and win
    do_clear();
    for (int i = 0; i < 27; i++) qb_land(28'h1 << i, 1'b0);
    check("fill27_color", {4'd0, color_state}, 32'h7FFFFFF);
    check("fill27_done", {27'd0, cubes_done}, 32'd27);
    @(negedge clk);
    qb_land_pos   = 28'h8000000;
    qb_land_valid = 1'b1;
    @(posedge clk);
    #1;
    qb_land_valid = 1'b0;
    check("win_n", {31'd0, win_pulse}, 32'd0);
    @(posedge clk);
    #1;
    check("win_n1_color", {4'd0, color_state}, 32'h7FFFFFF);
    @(posedge clk);
    #1;
    check("win_n2_color", {4'd0, color_state}, 32'hFFFFFFF);
    check("win_n2_done", {27'd0, cubes_done}, 32'd28);
    check("win_n2_pulse", {31'd0, win_pulse}, 32'd0);
    check("win_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("win_n3_pulse", {31'd0, win_pulse}, 32'd1);
    qb_land_pos   = 28'h1;
    qb_land_valid = 1'b1;
    wins    = 0;
    readies = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (qb_land_ready) readies++;
      @(posedge clk);
      #1;
      if (win_pulse) wins++;
    end
    check("win_extra_pulses", wins, 32'd0);
    check("win_readies", readies, 32'd0);
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("clear_cycle_ready", {31'd0, qb_land_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("clr_color", {4'd0, color_state}, 32'd0);
    check("clr_done", {27'd0, cubes_done}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("post_clear_ready", {31'd0, qb_land_ready}, 32'd1);
    qb_land_valid = 1'b0;

    // Clear while a request sits in CHECK
    qb_land(28'h8, 1'b0);
    check("pre_clr_color", {4'd0, color_state}, 32'h8);
    @(negedge clk);
    qb_land_pos   = 28'h2;
    qb_land_valid = 1'b1;
    @(posedge clk);
    #1;
    qb_land_valid = 1'b0;
    clear = 1'b1;
    check("chk_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("chkclr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("chkclr_color", {4'd0, color_state}, 32'd0);
    check("chkclr_done", {27'd0, cubes_done}, 32'd0);

    // Reset while a request sits in CHECK
    qb_land(28'h8, 1'b0);
    @(negedge clk);
    qb_land_pos   = 28'h2;
    qb_land_valid = 1'b1;
    @(posedge clk);
    #1;
    qb_land_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("chkrst_color", {4'd0, color_state}, 32'd0);
    check("chkrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("chkrst_color_after", {4'd0, color_state}, 32'd0);
    check("chkrst_done_after", {27'd0, cubes_done}, 32'd0);
    check("chkrst_busy_after", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
`default_nettype wire
